mdu_sequencer: RTL and testbench

Multi-cycle sequencer for RV32M multiply/divide operations issued from the EX stage alongside the single-cycle ALU. It accepts one M-extension request, runs a radix-2 shift-add multiplier or restoring divider for XLEN iterations, and applies sign fix-up. It stalls the pipeline front end until the result is ready and returns the result for one cycle so EX can write it back. It supports flush abort and early termination for divide special cases.

---
 rtl/mdu_sequencer_pkg.sv | 49 ++++
 rtl/mdu_sequencer_step.sv | 39 +++
 rtl/mdu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide sequencer.
package mdu_sequencer_pkg;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  function automatic logic op_rs1_signed(input mdu_op_e op);
    logic s;
    case (op)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: s = 1'b1;
      default:                                         s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic op_rs2_signed(input mdu_op_e op);
    logic s;
    case (op)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: s = 1'b1;
      default:                             s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_sequencer_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// {acc, lo} is the 2*XLEN product while multiplying; acc is the remainder and lo the quotient while dividing.
module mdu_step
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN:0]   acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;
  logic            qbit;

  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB is set, then shift the pair right.
    add_sum = acc_i + (lo_i[0] ? {1'b0, opnd_i} : '0);

    // Divide: shift the next dividend bit into the remainder and try subtracting the divisor.
    shifted = {acc_i, lo_i[XLEN-1]};
    trial   = shifted - {2'b00, opnd_i};
    qbit    = ~trial[XLEN+1];

    if (is_div_i) begin
      acc_o = qbit ? trial[XLEN:0] : shifted[XLEN:0];
      lo_o  = {lo_i[XLEN-2:0], qbit};
    end else begin
      acc_o = {1'b0, add_sum[XLEN:1]};
      lo_o  = {add_sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: accepts one request, iterates XLEN times,
// applies sign fix-up and presents the result for one cycle while stalling the front end.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN:0]     acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              result_valid_q, result_valid_d;

  logic [XLEN:0]     step_acc;
  logic [XLEN-1:0]   step_lo;

  mdu_op_e           req_op_e;
  logic              req_sign_a, req_sign_b;
  logic              req_div0, req_ovf;
  logic [XLEN-1:0]   req_abs_a, req_abs_b;

  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_value;

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .lo_o     (step_lo)
  );

  // Request decode: operand signs, magnitudes and the divide special cases.
  always_comb begin
    req_op_e   = mdu_op_e'(req_op);
    req_sign_a = op_rs1_signed(req_op_e) & rs1[XLEN-1];
    req_sign_b = op_rs2_signed(req_op_e) & rs2[XLEN-1];
    req_abs_a  = req_sign_a ? -rs1 : rs1;
    req_abs_b  = req_sign_b ? -rs2 : rs2;
    req_div0   = op_is_div(req_op_e) & (rs2 == '0);
    req_ovf    = ((req_op_e == MDU_DIV) | (req_op_e == MDU_REM)) &
                 (rs1 == MIN_NEG) & (rs2 == '1);
  end

  // Sign fix-up and result selection from the finished magnitudes.
  always_comb begin
    prod_mag = {acc_q[XLEN-1:0], lo_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    quot_fix = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix  = sign_a_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    if (op_is_div(op_q)) begin
      fix_value = op_is_rem(op_q) ? rem_fix : quot_fix;
    end else if (op_q == MDU_MUL) begin
      fix_value = prod_fix[XLEN-1:0];
    end else begin
      fix_value = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case leaves a signal unassigned and infers a latch.
    state_d        = state_q;
    op_d           = op_q;
    count_d        = count_q;
    sign_a_d       = sign_a_q;
    sign_b_d       = sign_b_q;
    acc_d          = acc_q;
    lo_d           = lo_q;
    opnd_d         = opnd_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = req_op_e;
          sign_a_d = req_sign_a;
          sign_b_d = req_sign_b;
          if (req_div0) begin
            result_d       = op_is_rem(req_op_e) ? rs1 : '1;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else if (req_ovf) begin
            result_d       = op_is_rem(req_op_e) ? '0 : MIN_NEG;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            acc_d   = '0;
            lo_d    = req_abs_a;
            opnd_d  = req_abs_b;
            count_d = '0;
            state_d = ITER;
          end
        end
      end

      ITER: begin
        acc_d   = step_acc;
        lo_d    = step_lo;
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        result_d       = fix_value;
        result_valid_d = 1'b1;
        state_d        = DONE;
      end

      DONE: begin
        result_valid_d = 1'b0;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Flush overrides everything, including an acceptance in IDLE.
    if (flush) begin
      state_d        = IDLE;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= MDU_MUL;
      count_q        <= '0;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      acc_q          <= '0;
      lo_q           <= '0;
      opnd_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
      state_q        <= state_d;
      op_q           <= op_d;
      count_q        <= count_d;
      sign_a_q       <= sign_a_d;
      sign_b_q       <= sign_b_d;
      acc_q          <= acc_d;
      lo_q           <= lo_d;
      opnd_q         <= opnd_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign stall        = ((state_q == IDLE) & req_valid & ~flush) |
                        (state_q == ITER) | (state_q == FIXUP);
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random ops
// against an arithmetic reference model, with flush, reset and back-to-back checks.
module tb_mdu_sequencer;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  mdu_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .rs1          (rs1),
    .rs2          (rs2),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RV32M semantics from plain 64-bit and signed arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] ua, ub, up;
    logic [63:0] bits;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin sp = sa * sb; bits = sp; return bits[31:0]; end
      3'd1: begin sp = sa * sb; bits = sp; return bits[63:32]; end
      3'd2: begin sp = sa * longint'(ub); bits = sp; return bits[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN_NEG;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE, scramble inputs after acceptance, and check latency, result and pulse width.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    bit          special;
    int          n;
    exp     = ref_model(op, a, b);
    special = op[2] && ((b == 0) || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    req_valid = 1'b1;
    req_op    = op;
    rs1       = a;
    rs2       = b;
    #1;
    check({tag, " stall_on_req"}, 32'(stall), 32'd1);
    tick();
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    rs1       = $urandom;
    rs2       = $urandom;
    n = 0;
    while (!result_valid && n < 100) begin
      check({tag, " stall_iter"}, 32'(stall), 32'd1);
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), special ? 32'd0 : 32'd33);
    check({tag, " result"}, result, exp);
    check({tag, " stall_done"}, 32'(stall), 32'd0);
    check({tag, " busy_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, " valid_drop"}, 32'(result_valid), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int first_e, second_e;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    rs1       = '0;
    rs2       = '0;
    flush     = 1'b0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(result_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul",       3'd0, 32'd7,        32'hFFFF_FFFD);
    run_op("mulh",      3'd1, MIN_NEG,      MIN_NEG);
    run_op("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op("div",       3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem",       3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",      3'd5, 32'd100,      32'd7);
    run_op("remu",      3'd7, 32'd100,      32'd7);
    run_op("div0",      3'd4, 32'd5,        32'd0);
    run_op("remu0",     3'd7, 32'd5,        32'd0);
    run_op("div_ovf",   3'd4, MIN_NEG,      32'hFFFF_FFFF);
    run_op("rem_ovf",   3'd6, MIN_NEG,      32'hFFFF_FFFF);
    run_op("divu_ovfop", 3'd5, MIN_NEG,     32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1;
    req_op    = 3'd0;
    rs1       = 32'd3;
    rs2       = 32'd4;
    flush     = 1'b1;
    #1;
    check("flush_idle stall", 32'(stall), 32'd0);
    tick();
    check("flush_idle busy", 32'(busy), 32'd0);
    req_valid = 1'b0;
    flush     = 1'b0;

    // Flush before edge 10 of a DIV.
    req_valid = 1'b1;
    req_op    = 3'd4;
    rs1       = 32'd1000;
    rs2       = 32'd7;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_iter busy", 32'(busy), 32'd0);
    check("flush_iter stall", 32'(stall), 32'd0);
    pulses = 0;
    for (int e = 0; e < 40; e++) begin
      if (result_valid) pulses++;
      tick();
    end
    check("flush_iter pulses", 32'(pulses), 32'd0);

    // Flush while in FIXUP (after edge 32) suppresses the pulse.
    req_valid = 1'b1;
    req_op    = 3'd0;
    rs1       = 32'd9;
    rs2       = 32'd9;
    tick();
    req_valid = 1'b0;
    repeat (32) tick();
    check("flush_fix stall", 32'(stall), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      if (result_valid) pulses++;
      tick();
    end
    check("flush_fix pulses", 32'(pulses), 32'd0);
    check("flush_fix busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-ITER.
    req_valid = 1'b1;
    req_op    = 3'd5;
    rs1       = 32'd12345;
    rs2       = 32'd17;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check("pre_reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset busy", 32'(busy), 32'd0);
    check("async_reset stall", 32'(stall), 32'd0);
    check("async_reset valid", 32'(result_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    run_op("post_reset", 3'd5, 32'd12345, 32'd17);

    // Back-to-back MULs with req_valid held high.
    req_valid = 1'b1;
    req_op    = 3'd0;
    rs1       = 32'd123;
    rs2       = 32'hFFFF_FF00;
    pulses    = 0;
    first_e   = -1;
    second_e  = -1;
    tick();
    for (int e = 1; e <= 69; e++) begin
      tick();
      if (result_valid) begin
        pulses++;
        if (first_e < 0) first_e = e;
        else if (second_e < 0) second_e = e;
        check("b2b result", result, ref_model(3'd0, 32'd123, 32'hFFFF_FF00));
      end
      if (e == 33) check("b2b stall_done", 32'(stall), 32'd0);
    end
    req_valid = 1'b0;
    tick();
    tick();
    check("b2b pulses", 32'(pulses), 32'd2);
    check("b2b first", 32'(first_e), 32'd33);
    check("b2b spacing", 32'(second_e - first_e), 32'd35);
    check("b2b busy_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
